// File: rtl/somador_pkg.sv
// Shared types and constants for the signed-adder control unit and its arbiter.
// The package holds the FSM state encoding and the decode of one-hot datapath strobes.
package somador_pkg;

  localparam int N_DEFAULT = 5;
  localparam int SEQ_LEN   = 6;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_AB   = 3'd1,
    LD_MAG  = 3'd2,
    CMP_MAG = 3'd3,
    CMP_SIN = 3'd4,
    SOMA    = 3'd5,
    LD_RES  = 3'd6,
    DONE    = 3'd7
  } somador_state_t;

  // Bit positions inside the strobe vector, in firing order.
  localparam int STB_LOAD_AB     = 0;
  localparam int STB_LOADMAG_AB  = 1;
  localparam int STB_COMP_MAG    = 2;
  localparam int STB_COMP_SINAIS = 3;
  localparam int STB_SOMA_SUB    = 4;
  localparam int STB_LOAD_RES    = 5;

  typedef logic [SEQ_LEN-1:0] strobe_vec_t;

  function automatic strobe_vec_t decode_strobes(somador_state_t s);
    strobe_vec_t v;
    v = '0;
    case (s)
      LD_AB:   v[STB_LOAD_AB]     = 1'b1;
      LD_MAG:  v[STB_LOADMAG_AB]  = 1'b1;
      CMP_MAG: v[STB_COMP_MAG]    = 1'b1;
      CMP_SIN: v[STB_COMP_SINAIS] = 1'b1;
      SOMA:    v[STB_SOMA_SUB]    = 1'b1;
      LD_RES:  v[STB_LOAD_RES]    = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Successor within the fixed strobe sequence; IDLE is left by arbitration only.
  function automatic somador_state_t seq_next(somador_state_t s);
    somador_state_t n;
    case (s)
      LD_AB:   n = LD_MAG;
      LD_MAG:  n = CMP_MAG;
      CMP_MAG: n = CMP_SIN;
      CMP_SIN: n = SOMA;
      SOMA:    n = LD_RES;
      LD_RES:  n = DONE;
      DONE:    n = IDLE;
      default: n = IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/somador_ctrl_arb_rr_arb2.sv
// Two-input round-robin arbiter, purely combinational.
// The parent holds last_grant; on contention the client that did not win last time wins now.
module rr_arb2
  import somador_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = req0 | req1;
    if (req0 && req1) begin
      gnt_id = ~last_grant;
    end else begin
      gnt_id = req1;
    end
  end

endmodule

// File: rtl/somador_ctrl_arb.sv
// Control unit and two-client arbiter for the signed adder datapath.
// Grants the adder round-robin, steps six one-hot strobes, then pulses the owner's done.
module somador_ctrl_arb
  import somador_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         RESET,
  input  logic         req0,
  input  logic         req1,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] b0,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b1,
  output logic [N-1:0] a_out,
  output logic [N-1:0] b_out,
  output logic         loadAB,
  output logic         loadmagAB,
  output logic         comp_mag,
  output logic         comp_sinais,
  output logic         soma_sub,
  output logic         loadRES,
  output logic         busy,
  output logic         grant_id,
  output logic         done0,
  output logic         done1
);

  somador_state_t state_q, state_d;
  logic           grant_id_q, grant_id_d;
  logic           last_grant_q, last_grant_d;
  strobe_vec_t    strobes_q, strobes_d;
  logic           busy_q, busy_d;
  logic           done0_q, done0_d;
  logic           done1_q, done1_d;

  logic gnt_valid;
  logic gnt_id;

  rr_arb2 u_arb (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          grant_id_d   = gnt_id;
          last_grant_d = gnt_id;
          state_d      = LD_AB;
        end
      end
      default: state_d = seq_next(state_q);
    endcase

    // Outputs are decoded from the next state and registered so they align with the state.
    strobes_d = decode_strobes(state_d);
    busy_d    = (state_d != IDLE);
    done0_d   = (state_d == DONE) && !grant_id_d;
    done1_d   = (state_d == DONE) &&  grant_id_d;
  end

  always_ff @(posedge clk) begin
    if (!RESET) begin
      state_q      <= IDLE;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      strobes_q    <= '0;
      busy_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      strobes_q    <= strobes_d;
      busy_q       <= busy_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
    end
  end

  // The datapath re-reads raw operands in LD_MAG, so the mux stays live every cycle.
  assign a_out = grant_id_q ? a1 : a0;
  assign b_out = grant_id_q ? b1 : b0;

  assign loadAB      = strobes_q[STB_LOAD_AB];
  assign loadmagAB   = strobes_q[STB_LOADMAG_AB];
  assign comp_mag    = strobes_q[STB_COMP_MAG];
  assign comp_sinais = strobes_q[STB_COMP_SINAIS];
  assign soma_sub    = strobes_q[STB_SOMA_SUB];
  assign loadRES     = strobes_q[STB_LOAD_RES];
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;
  assign done0       = done0_q;
  assign done1       = done1_q;

endmodule
